mem_access_ctrl: RTL and testbench

Memory-stage access controller sitting directly upstream of the word-organised data memory (1024 × 32, combinational read, synchronous write). Accepts one load/store request at a time from the CPU's MEM stage through a valid/ready handshake. Performs byte/halfword/word alignment checks, does read-modify-write for sub-word stores, and sign/zero-extends loads. Returns exactly one response per accepted request.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_align.sv | 49 ++++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage access path.
//   - MEM_B / MEM_H / MEM_W : req_size encodings (2'b11 is illegal)
//   - state_t               : access controller states
//   - misaligned()          : alignment / legality check for a request
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Size 2'b11 is treated as misaligned so it takes the error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = lo[0];
            MEM_W:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational little-endian lane handling.
//   size   in  2   MEM_B / MEM_H / MEM_W
//   lane   in  2   byte address bits [1:0]
//   sign   in  1   sign-extend sub-word loads
//   wdata  in  32  right-justified store data
//   rword  in  32  current memory word
//   merged out 32  rword with the target lane replaced (wdata for words)
//   loaded out 32  extracted and extended load value (rword for words)
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  bsh;
    logic [4:0]  hsh;

    assign bsh = {lane, 3'b000};
    assign hsh = {lane[1], 4'b0000};
    assign b   = rword[bsh +: 8];
    assign h   = rword[hsh +: 16];

    always_comb begin
        merged = wdata;
        loaded = rword;
        case (size)
            MEM_B: begin
                merged          = rword;
                merged[bsh +: 8] = wdata[7:0];
                loaded          = {{24{sign & b[7]}}, b};
            end
            MEM_H: begin
                merged           = rword;
                merged[hsh +: 16] = wdata[15:0];
                loaded           = {{16{sign & h[15]}}, h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller in front of a
// word-organised data memory (combinational read, synchronous write).
//   clk, reset (async, active-high)
//   req_valid/req_ready, req_we, req_size, req_sign, req_addr, req_wdata, req_pc
//   resp_valid, resp_rdata, resp_err  : one-cycle response strobe
//   ram_addr, ram_we, ram_wdata, ram_rdata : data memory port
// Optional: define MEM_TRACE_EN to print one trace line per memory write.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t      state, state_nxt;
    logic        we_q, sign_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic [31:0] merged, loaded;
    logic        req_bad;

    assign req_bad = misaligned(req_size, req_addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_valid) begin
                we_q    <= req_we;
                sign_q  <= req_sign;
                err_q   <= req_bad;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ST_RD)
                word_q <= ram_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) begin
                if (req_bad)                        state_nxt = ST_RESP;
                else if (req_we && req_size == MEM_W) state_nxt = ST_WR;
                else                                state_nxt = ST_RD;
            end
            ST_RD:   state_nxt = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Word stores never pass through RD, so merged falls back to wdata_q.
    mem_align u_align (
        .size   (size_q),
        .lane   (addr_q[1:0]),
        .sign   (sign_q),
        .wdata  (wdata_q),
        .rword  (word_q),
        .merged (merged),
        .loaded (loaded)
    );

    // All outputs decode registered state only; nothing combinational from req_*.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && err_q;
        resp_rdata = (state == ST_RESP && !err_q && !we_q) ? loaded : 32'h0;
        ram_we     = (state == ST_WR);
        ram_addr   = (state == ST_RD || state == ST_WR) ? addr_q[ADDR_W+1:2] : '0;
        ram_wdata  = (state == ST_WR) ? merged : 32'h0;
    end

`ifdef MEM_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= '0;
        else if (state == ST_IDLE && req_valid)
            pc_q <= req_pc;
    end

    always @(posedge clk) begin
        if (ram_we && !reset)
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, ram_wdata);
    end
`else
    // PC and upper address bits only feed the trace.
    logic unused_trace;
    assign unused_trace = ^{req_pc, addr_q[31:ADDR_W+2]};
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        resp_valid, resp_err, ram_we;
    logic [31:0] resp_rdata, ram_wdata, ram_rdata;
    logic [9:0]  ram_addr;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Data memory the controller drives.
    logic [31:0] mem [0:1023];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    // Reference memory image, updated when a request is issued.
    logic [31:0] ref_mem [0:1023];

    typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
    typedef struct { logic [9:0] addr; logic [31:0] data; int cyc; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or a write.
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (rq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else begin
                    resp_t e;
                    e = rq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("resp_cycle", cyc, e.cyc);
                end
            end
            if (ram_we) begin
                if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("ram_addr", {22'd0, ram_addr}, {22'd0, w.addr});
                    chk("ram_wdata", ram_wdata, w.data);
                    chk("write_cycle", cyc, w.cyc);
                end
            end
        end
    end

    // Issue one request; when track=1 the reference model predicts its effects.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, input logic track);
        int      n, acc, sh;
        logic    bad;
        logic [9:0]  idx;
        logic [31:0] w, v, mask, res;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        acc = cyc + 1;
        if (track) begin
            bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
            idx = addr[11:2];
            w   = ref_mem[idx];
            sh  = 8 * int'(addr[1:0]);
            mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (bad) rq.push_back('{32'h0, 1'b1, acc});
            else if (!we) begin
                v = (w >> sh) & mask;
                if (sign && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (sign && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
                rq.push_back('{v, 1'b0, acc + 1});
            end else begin
                res = (w & ~(mask << sh)) | ((wdata & mask) << sh);
                ref_mem[idx] = res;
                if (size == 2'd2) begin
                    wq.push_back('{idx, res, acc});
                    rq.push_back('{32'h0, 1'b0, acc + 1});
                end else begin
                    wq.push_back('{idx, res, acc + 1});
                    rq.push_back('{32'h0, 1'b0, acc + 2});
                end
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom(); req_wdata = $urandom(); req_size = 2'($urandom_range(0, 3));
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 1024; i++) begin
            r = $urandom();
            mem[i] <= r;
            ref_mem[i] = r;
        end
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; req_pc = '0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h100, 1'b1);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 32'h104, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h108, 1'b1);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF00FF, 32'h10C, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h110, 1'b1);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h114, 1'b1);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h118, 1'b1);
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'hBEEF, 32'h11C, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 32'h120, 1'b1);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h124, 1'b1);
        do_req(1'b1, 2'd2, 1'b0, 32'h1004, 32'hCAFEF00D, 32'h128, 1'b1);

        // Reset during the WR cycle of a byte store: the write must be dropped.
        repeat (4) @(negedge clk);
        do_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h5A, 32'h200, 1'b0);
        @(posedge clk); #1;
        chk("wr_state_we", {31'd0, ram_we}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_mem_kept", mem[12], ref_mem[12]);
        repeat (3) @(negedge clk);

        // Randomized traffic over a small window so accesses overlap.
        for (int k = 0; k < 300; k++) begin
            r = $urandom();
            do_req(r[0], r[2:1], r[3], $urandom() & 32'hFFFF_F03F, $urandom(), $urandom(), 1'b1);
            if (r[7:4] == 4'd0) repeat (2) @(negedge clk);
        end

        for (int n = 0; n < 20 && (rq.size() != 0 || wq.size() != 0); n++) @(negedge clk);
        chk("resp_queue_drained", rq.size(), 32'd0);
        chk("write_queue_drained", wq.size(), 32'd0);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
